// File: rtl/sha256d_sched_pkg.sv
// Shared types and round-robin pick helper for the sha256d nonce scheduler.
// Pure declarations; no state, no flow control.
package sha256d_sched_pkg;

  localparam int NONCE_W_DEF = 32;
  localparam int MAX_CORES   = 16;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} sched_state_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } rr_pick_t;

  // Lowest set bit of mask at or after ptr, wrapping at n. Descending scan so the
  // smallest offset from ptr is written last and wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_CORES-1:0] mask,
                                       input logic [3:0] ptr,
                                       input int n);
    rr_pick_t   r;
    logic [4:0] sum;
    r = '0;
    for (int k = MAX_CORES - 1; k >= 0; k--) begin
      if (k < n) begin
        sum = {1'b0, ptr} + 5'(k);
        if (sum >= 5'(n)) sum = sum - 5'(n);
        if (mask[sum[3:0]]) begin
          r.vld = 1'b1;
          r.idx = sum[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256d_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at/after ptr_i.
// Zero latency; no backpressure, the caller owns the pointer and decides whether to use the grant.
module sha256d_rr_arbiter import sha256d_sched_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_CORES-1:0] gnt_o,
  output logic [PTR_W-1:0]     gnt_idx_o,
  output logic                 gnt_vld_o
);

  rr_pick_t pick;

  always_comb begin
    pick      = rr_pick(MAX_CORES'(req_i), 4'(ptr_i), NUM_CORES);
    gnt_vld_o = pick.vld;
    gnt_idx_o = PTR_W'(pick.idx);
    gnt_o     = pick.vld ? (NUM_CORES'(1) << pick.idx) : '0;
  end

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// Dispatches nonces [first,last] round-robin to idle sha256d cores and records the first hit; core_start is
// registered one cycle after an idle core is seen. Optional SCHED_HASH_COUNT_EN adds a saturating hash_count.
module sha256d_nonce_scheduler import sha256d_sched_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = NONCE_W_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [NONCE_W-1:0]   cfg_nonce_first,
  input  logic [NONCE_W-1:0]   cfg_nonce_last,
  input  logic [NUM_CORES-1:0] core_idle,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NONCE_W-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_hit,
`ifdef SCHED_HASH_COUNT_EN
  output logic [63:0]          hash_count,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [NONCE_W-1:0]   found_nonce
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_e         state_q, state_d;
  logic [NONCE_W:0]     next_nonce_q, next_nonce_d;
  logic [NONCE_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] in_flight_q, in_flight_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [NONCE_W-1:0]   core_nonce_q, core_nonce_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [NONCE_W-1:0]   core_tag_q [NUM_CORES];

  logic [NUM_CORES-1:0] gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [NUM_CORES-1:0] hit_vec;
  logic [PTR_W-1:0]     hit_idx;
  logic                 hit_any;
  logic                 start_acc;
  logic                 exhausted;

  sha256d_rr_arbiter #(.NUM_CORES(NUM_CORES), .PTR_W(PTR_W)) u_arb (
    .req_i     (core_idle & ~in_flight_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Done pulses from cores we never launched (or forgot across reset) carry no hit.
  always_comb begin
    hit_vec = core_done & core_hit & in_flight_q;
    hit_any = |hit_vec;
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = PTR_W'(i);
    end
  end

  assign start_acc = cfg_start && (state_q == IDLE || state_q == DONE);
  assign exhausted = next_nonce_q > {1'b0, last_q};

  always_comb begin
    state_d       = state_q;
    next_nonce_d  = next_nonce_q;
    last_d        = last_q;
    rr_ptr_d      = rr_ptr_q;
    core_start_d  = '0;
    core_nonce_d  = core_nonce_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    in_flight_d   = in_flight_q & ~core_done;

    if (!found_q && hit_any) begin
      found_d       = 1'b1;
      found_nonce_d = core_tag_q[hit_idx];
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d       = DISPATCH;
          next_nonce_d  = {1'b0, cfg_nonce_first};
          last_d        = cfg_nonce_last;
          found_d       = 1'b0;
          found_nonce_d = '0;
        end
      end
      DISPATCH: begin
        // A grant decided alongside a hit still goes out; abort suppresses it.
        if (!exhausted && !cfg_abort && gnt_vld) begin
          core_start_d = gnt;
          core_nonce_d = next_nonce_q[NONCE_W-1:0];
          next_nonce_d = next_nonce_q + (NONCE_W+1)'(1);
          rr_ptr_d     = (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + PTR_W'(1);
          in_flight_d  = in_flight_d | gnt;
        end
        if ((next_nonce_d > {1'b0, last_q}) || cfg_abort || hit_any) begin
          state_d = (in_flight_d == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (in_flight_d == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      next_nonce_q  <= '0;
      last_q        <= '0;
      rr_ptr_q      <= '0;
      in_flight_q   <= '0;
      core_start_q  <= '0;
      core_nonce_q  <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_tag_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      next_nonce_q  <= next_nonce_d;
      last_q        <= last_d;
      rr_ptr_q      <= rr_ptr_d;
      in_flight_q   <= in_flight_d;
      core_start_q  <= core_start_d;
      core_nonce_q  <= core_nonce_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_start_d[i]) core_tag_q[i] <= core_nonce_d;
      end
    end
  end

`ifdef SCHED_HASH_COUNT_EN
  logic [63:0] hash_cnt_q, hash_cnt_d;
  logic [64:0] hash_sum;

  always_comb begin
    hash_sum   = {1'b0, hash_cnt_q} + 65'($countones(core_done & in_flight_q));
    hash_cnt_d = hash_sum[64] ? '1 : hash_sum[63:0];
    if (start_acc) hash_cnt_d = '0;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) hash_cnt_q <= '0;
    else          hash_cnt_q <= hash_cnt_d;
  end

  assign hash_count = hash_cnt_q;
`endif

  assign core_start  = core_start_q;
  assign core_nonce  = core_nonce_q;
  assign busy        = (state_q == DISPATCH) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign found_nonce = found_nonce_q;

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Bench for sha256d_nonce_scheduler: directed runs against a fixed-latency core model,
// expected dispatches/results queued per run and popped by a negedge monitor.
module tb_sha256d_nonce_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_nonce_first = '0;
  logic [31:0] cfg_nonce_last = '0;
  logic [3:0]  core_idle = '1;
  logic [3:0]  core_done = '0;
  logic [3:0]  core_hit = '0;
  logic [3:0]  core_start;
  logic [31:0] core_nonce;
  logic        busy, done, found;
  logic [31:0] found_nonce;
`ifdef SCHED_HASH_COUNT_EN
  logic [63:0] hash_count;
`endif

  sha256d_nonce_scheduler #(.NUM_CORES(4), .NONCE_W(32)) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_nonce_first (cfg_nonce_first),
    .cfg_nonce_last  (cfg_nonce_last),
    .core_idle       (core_idle),
    .core_start      (core_start),
    .core_nonce      (core_nonce),
    .core_done       (core_done),
    .core_hit        (core_hit),
`ifdef SCHED_HASH_COUNT_EN
    .hash_count      (hash_count),
`endif
    .busy            (busy),
    .done            (done),
    .found           (found),
    .found_nonce     (found_nonce)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [3:0]  onehot;
    logic [31:0] nonce;
  } disp_t;

  typedef struct packed {
    logic        fnd;
    logic [31:0] nonce;
  } res_t;

  disp_t exp_q[$];
  res_t  res_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  int          lat [4] = '{3, 3, 3, 3};
  int          cnt [4] = '{0, 0, 0, 0};
  logic [31:0] tag [4];
  bit          hit_en = 1'b0;
  logic [31:0] hit_a = '0;
  logic [31:0] hit_b = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_disp(input int core, input logic [31:0] n);
    disp_t d;
    d.onehot = 4'b0001 << core;
    d.nonce  = n;
    exp_q.push_back(d);
  endtask

  task automatic push_res(input logic f, input logic [31:0] n);
    res_t r;
    r.fnd   = f;
    r.nonce = n;
    res_q.push_back(r);
  endtask

  // Core array model: done (with hit) lat[i] cycles after its core_start; reset clears it.
  always @(negedge ACLK) begin
    #1;
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      core_idle = '1;
      core_done = '0;
      core_hit  = '0;
    end else begin
      core_done = '0;
      core_hit  = '0;
      for (int i = 0; i < 4; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            core_done[i] = 1'b1;
            core_hit[i]  = hit_en && (tag[i] == hit_a || tag[i] == hit_b);
            core_idle[i] = 1'b1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (core_start[i]) begin
          cnt[i]       = lat[i];
          tag[i]       = core_nonce;
          core_idle[i] = 1'b0;
        end
      end
    end
  end

  logic done_prev = 1'b0;

  always @(negedge ACLK) begin
    disp_t d;
    res_t  r;
    if (core_start != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dispatch: core_start=%b nonce=%0h, no dispatch expected", core_start, core_nonce);
      end else begin
        d = exp_q.pop_front();
        check("dispatch_core", 64'(core_start), 64'(d.onehot));
        check("dispatch_nonce", 64'(core_nonce), 64'(d.nonce));
      end
    end
    if (done && !done_prev) begin
      if (res_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: found=%b found_nonce=%0h, no result expected", found, found_nonce);
      end else begin
        r = res_q.pop_front();
        check("result_found", 64'(found), 64'(r.fnd));
        check("result_nonce", 64'(found_nonce), 64'(r.nonce));
      end
    end
    done_prev = done;
  end

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic start_run(input logic [31:0] f, input logic [31:0] l, input bit with_abort);
    @(negedge ACLK);
    cfg_nonce_first = f;
    cfg_nonce_last  = l;
    cfg_start       = 1'b1;
    cfg_abort       = with_abort;
    @(negedge ACLK);
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 300 && !done; k++) @(negedge ACLK);
    check({name, "_done_reached"}, 64'(done), 64'(1));
    @(negedge ACLK);
    check({name, "_dispatches_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    check({name, "_found"}, 64'(found), 64'(0));
    check({name, "_found_nonce"}, 64'(found_nonce), 64'(0));
    check({name, "_core_start"}, 64'(core_start), 64'(0));
    check({name, "_core_nonce"}, 64'(core_nonce), 64'(0));
  endtask

  initial begin
    do_reset();
    @(negedge ACLK);
    check_reset_vals("reset");

    // Plain 8-nonce run; a start pulse mid-run must be ignored.
    for (int i = 0; i < 8; i++) push_disp(i % 4, 32'h10 + 32'(i));
    push_res(1'b0, 32'h0);
    start_run(32'h10, 32'h17, 1'b0);
    @(negedge ACLK);
    @(negedge ACLK);
    cfg_nonce_first = 32'h99;
    cfg_nonce_last  = 32'h9F;
    cfg_start       = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    wait_done("plain");

    // Hit on 0x11 arrives with the grant of 0x14 in the same cycle.
    do_reset();
    hit_en = 1'b1; hit_a = 32'h11; hit_b = 32'h11;
    push_disp(0, 32'h10); push_disp(1, 32'h11); push_disp(2, 32'h12);
    push_disp(3, 32'h13); push_disp(0, 32'h14);
    push_res(1'b1, 32'h11);
    start_run(32'h10, 32'h1F, 1'b0);
    wait_done("hit");
    hit_en = 1'b0;

    // From DONE, start with abort together; top-of-range must not wrap.
    push_disp(1, 32'hFFFF_FFFE); push_disp(2, 32'hFFFF_FFFF);
    push_res(1'b0, 32'h0);
    start_run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
    wait_done("top");

    // Empty range.
    do_reset();
    push_res(1'b0, 32'h0);
    start_run(32'h5, 32'h4, 1'b0);
    check("empty_done_c1", 64'(done), 64'(0));
    @(negedge ACLK);
    check("empty_done_c2", 64'(done), 64'(1));
    wait_done("empty");

    // Simultaneous hits on cores 1 and 3.
    do_reset();
    lat[3] = 1;
    hit_en = 1'b1; hit_a = 32'h21; hit_b = 32'h23;
    push_disp(0, 32'h20); push_disp(1, 32'h21); push_disp(2, 32'h22);
    push_disp(3, 32'h23); push_disp(0, 32'h24);
    push_res(1'b1, 32'h21);
    start_run(32'h20, 32'h27, 1'b0);
    wait_done("dual_hit");
    lat[3] = 3;
    hit_en = 1'b0;

    // Abort mid-range.
    do_reset();
    push_disp(0, 32'h30); push_disp(1, 32'h31);
    push_res(1'b0, 32'h0);
    start_run(32'h30, 32'h3F, 1'b0);
    @(negedge ACLK);
    @(negedge ACLK);
    cfg_abort = 1'b1;
    @(negedge ACLK);
    cfg_abort = 1'b0;
    wait_done("abort");

    // One-cycle reset during DISPATCH, then a fresh run.
    do_reset();
    push_disp(0, 32'h40); push_disp(1, 32'h41);
    start_run(32'h40, 32'h47, 1'b0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check_reset_vals("midreset");
    ARESETN = 1'b1;
    check("midreset_dispatches_left", 64'(exp_q.size()), 64'(0));

    for (int i = 0; i < 8; i++) push_disp(i % 4, 32'h10 + 32'(i));
    push_res(1'b0, 32'h0);
    start_run(32'h10, 32'h17, 1'b0);
    wait_done("after_reset");
`ifdef SCHED_HASH_COUNT_EN
    check("hash_count", hash_count, 64'd8);
`endif
    check("results_left", 64'(res_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
